// File: rtl/zedern_pkg.sv
// Shared fetch-path definitions: datapath width, instruction size, NOP encoding
// and the fetch buffer entry layout.
package zedern_pkg;

   localparam int XLEN        = 32;
   localparam int INSTR_BYTES = 4;

   localparam logic [XLEN-1:0] NOP_INSTR     = 32'h0000_0013;
   localparam logic [XLEN-1:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

   // Redirect targets are forced onto an instruction boundary.
   function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
      return addr & PC_ALIGN_MASK;
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-to-decode instruction handshake. Handshake rule: a transfer happens on a
// rising clk edge where out_valid=1 and out_ready=1; while out_valid=1 and
// out_ready=0 the producer holds out_instr/out_pc stable.
interface fetch_out_if;
   import zedern_pkg::*;

   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_instr;
   logic [XLEN-1:0] out_pc;

   modport master (output out_valid, output out_instr, output out_pc, input out_ready);
   modport slave  (input out_valid, input out_instr, input out_pc, output out_ready);

endinterface

// File: rtl/fetch_fifo.sv
// Fetch buffer: DEPTH-entry FIFO of {pc, instr} with synchronous push/pop and a
// flush that empties it in one cycle. Head entry is read combinationally.
module fetch_fifo
   import zedern_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         push,
   input  fetch_entry_t push_data,
   input  logic         pop,
   output fetch_entry_t head_data,
   output logic         full,
   output logic         empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [PTR_W:0] wr_ptr;
   logic [PTR_W:0] rd_ptr;
   fetch_entry_t   mem [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr[PTR_W-1:0]] <= push_data;
   end

   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign head_data = mem[rd_ptr[PTR_W-1:0]];

endmodule

// File: rtl/fetch_unit.sv
// Sequential instruction fetch with a small decoupling buffer and redirect flush.
// Optional accepted-instruction counter enabled by defining ZEDERN_FETCH_CNT_EN.
module fetch_unit
   import zedern_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
   parameter int              BUF_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic [XLEN-1:0] imem_addr,
   input  logic [XLEN-1:0] imem_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   fetch_out_if.master     out_if
`ifdef ZEDERN_FETCH_CNT_EN
   ,
   output logic [XLEN-1:0] fetch_cnt
`endif
);

   localparam logic [XLEN-1:0] PC_STEP = XLEN'(INSTR_BYTES);

   logic [XLEN-1:0] pc_q;
   logic            push;
   logic            pop;
   logic            full;
   logic            empty;
   fetch_entry_t    push_entry;
   fetch_entry_t    head;

   // Redirect wins over everything: no pop and no push in a redirect cycle.
   assign pop  = out_if.out_valid & out_if.out_ready & ~redirect_valid;
   assign push = ~redirect_valid & (~full | pop);

   assign imem_addr        = pc_q;
   assign push_entry.pc    = pc_q;
   assign push_entry.instr = imem_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q <= RESET_PC;
      end else if (redirect_valid) begin
         pc_q <= align_pc(redirect_pc);
      end else if (push) begin
         pc_q <= pc_q + PC_STEP;
      end
   end

   fetch_fifo #(
      .DEPTH (BUF_DEPTH)
   ) u_fetch_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (redirect_valid),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .head_data (head),
      .full      (full),
      .empty     (empty)
   );

   assign out_if.out_valid = ~empty;
   assign out_if.out_instr = empty ? NOP_INSTR : head.instr;
   assign out_if.out_pc    = empty ? '0 : head.pc;

`ifdef ZEDERN_FETCH_CNT_EN
   localparam logic [XLEN-1:0] CNT_ONE = {{(XLEN-1){1'b0}}, 1'b1};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_cnt <= '0;
      end else if (pop) begin
         fetch_cnt <= fetch_cnt + CNT_ONE;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed reset/backpressure/redirect/wrap/reset-mid-run
// sequences plus random ready/redirect traffic against an expected-entry queue.
module tb_fetch_unit;
   import zedern_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] imem_addr, imem_data;
   logic [31:0] w_imem_addr, w_imem_data;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc    = 32'h0;
   logic        w_redirect_valid = 1'b0;
   logic [31:0] w_redirect_pc    = 32'h0;

   fetch_out_if ou ();
   fetch_out_if wo ();

`ifdef ZEDERN_FETCH_CNT_EN
   logic [31:0] fetch_cnt, w_fetch_cnt;
`endif

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
   endfunction

   assign imem_data   = instr_of(imem_addr);
   assign w_imem_data = instr_of(w_imem_addr);

   fetch_unit #(.RESET_PC(32'h0000_0100), .BUF_DEPTH(2)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_addr      (imem_addr),
      .imem_data      (imem_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_if         (ou)
`ifdef ZEDERN_FETCH_CNT_EN
      ,
      .fetch_cnt      (fetch_cnt)
`endif
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(2)) dut_wrap (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_addr      (w_imem_addr),
      .imem_data      (w_imem_data),
      .redirect_valid (w_redirect_valid),
      .redirect_pc    (w_redirect_pc),
      .out_if         (wo)
`ifdef ZEDERN_FETCH_CNT_EN
      ,
      .fetch_cnt      (w_fetch_cnt)
`endif
   );

   // ---------------- scoreboard ----------------
   int          n_checks = 0;
   int          n_errors = 0;
   int          hs_cnt   = 0;
   bit          sb_en    = 1'b0;
   logic [63:0] exp_q[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic load_exp(input logic [31:0] start);
      logic [31:0] a;
      exp_q.delete();
      for (int i = 0; i < 512; i++) begin
         a = start + 32'(i * 4);
         exp_q.push_back({a, instr_of(a)});
      end
   endtask

   // Inputs change at posedge+1, so at negedge they show what the next edge will see.
   always @(negedge clk) begin
      if (sb_en && rst_n) begin
         if (ou.out_valid && ou.out_ready && !redirect_valid) begin
            if (exp_q.size() == 0) begin
               check("sb_underflow", 64'd1, 64'd0);
            end else begin
               check("sb_entry", {ou.out_pc, ou.out_instr}, exp_q.pop_front());
            end
            hs_cnt++;
         end
         if (!ou.out_valid) check("empty_nop", {ou.out_pc, ou.out_instr}, {32'h0, NOP_INSTR});
      end
   end

   // ---------------- driver helpers ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] t;
   logic [31:0] rp;

   initial begin
      ou.out_ready = 1'b0;
      wo.out_ready = 1'b1;

      // reset state
      #12;
      check("rst_valid", 64'(ou.out_valid), 64'd0);
      check("rst_instr", 64'(ou.out_instr), 64'(NOP_INSTR));
      check("rst_pc", 64'(ou.out_pc), 64'd0);
      check("rst_imem_addr", 64'(imem_addr), 64'h100);
      check("rst_wrap_addr", 64'(w_imem_addr), 64'hFFFF_FFF8);
`ifdef ZEDERN_FETCH_CNT_EN
      check("rst_cnt", 64'(fetch_cnt), 64'd0);
`endif

      // release: sequential stream from RESET_PC, and wrap on the second instance
      cyc();
      rst_n        = 1'b1;
      ou.out_ready = 1'b1;
      load_exp(32'h100);
      hs_cnt = 0;
      sb_en  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         check("start_valid", 64'(ou.out_valid), 64'd1);
         t = 32'h100 + 32'(4 * i);
         check("start_pc", 64'(ou.out_pc), 64'(t));
         t = 32'hFFFF_FFF8 + 32'(4 * i);
         check("wrap_pc", 64'(wo.out_pc), 64'(t));
         check("wrap_instr", 64'(wo.out_instr), 64'(instr_of(t)));
      end

      // backpressure: head 0x108 held, buffer fills, PC stops at 0x110
      ou.out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cyc();
         check("bp_valid", 64'(ou.out_valid), 64'd1);
         check("bp_hold_pc", 64'(ou.out_pc), 64'h108);
      end
      check("bp_pc_hold", 64'(imem_addr), 64'h110);
      ou.out_ready = 1'b1;
      cyc();
      check("bp_rel_pc0", 64'(ou.out_pc), 64'h10C);
      cyc();
      check("bp_rel_pc1", 64'(ou.out_pc), 64'h110);

      // redirect while full with ready high
      redirect_valid = 1'b1;
      redirect_pc    = 32'h203;
      load_exp(32'h200);
      cyc();
      redirect_valid = 1'b0;
      check("redir_gap", 64'(ou.out_valid), 64'd0);
      check("redir_addr", 64'(imem_addr), 64'h200);
      cyc();
      check("redir_valid", 64'(ou.out_valid), 64'd1);
      check("redir_entry", {ou.out_pc, ou.out_instr}, {32'h200, instr_of(32'h200)});

      // random ready / redirect traffic
      for (int i = 0; i < 300; i++) begin
         ou.out_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 19) == 0) begin
            rp             = $urandom;
            redirect_valid = 1'b1;
            redirect_pc    = rp;
            load_exp(rp & 32'hFFFF_FFFC);
         end else begin
            redirect_valid = 1'b0;
         end
         cyc();
      end
      redirect_valid = 1'b0;

      // reset asserted mid-cycle with two entries buffered
      ou.out_ready = 1'b0;
      cyc();
      cyc();
      #2;
      sb_en = 1'b0;
      rst_n = 1'b0;
      #1;
      check("mrst_valid", 64'(ou.out_valid), 64'd0);
      check("mrst_pc", 64'(ou.out_pc), 64'd0);
      check("mrst_instr", 64'(ou.out_instr), 64'(NOP_INSTR));
      check("mrst_addr", 64'(imem_addr), 64'h100);
`ifdef ZEDERN_FETCH_CNT_EN
      check("mrst_cnt", 64'(fetch_cnt), 64'd0);
`endif
      cyc();
      cyc();
      rst_n        = 1'b1;
      ou.out_ready = 1'b1;
      load_exp(32'h100);
      hs_cnt = 0;
      sb_en  = 1'b1;

      // ten handshakes, then a redirect that flushes two buffered entries
      for (int i = 0; i < 50 && hs_cnt < 10; i++) cyc();
      if (hs_cnt != 10) check("hs_timeout", 64'(hs_cnt), 64'd10);
      ou.out_ready = 1'b0;
      cyc();
      cyc();
      check("cnt_full_valid", 64'(ou.out_valid), 64'd1);
      ou.out_ready   = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h300;
      load_exp(32'h300);
      cyc();
      redirect_valid = 1'b0;
      check("cnt_redir_gap", 64'(ou.out_valid), 64'd0);
`ifdef ZEDERN_FETCH_CNT_EN
      check("cnt_ten", 64'(fetch_cnt), 64'd10);
`endif
      for (int i = 0; i < 8; i++) cyc();
`ifdef ZEDERN_FETCH_CNT_EN
      check("cnt_final", 64'(fetch_cnt), 64'(hs_cnt));
`endif
      check("tail_valid", 64'(ou.out_valid), 64'd1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC loaded on reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 2, fetch buffer entries (power of two, >=2).
REQ-003 SHALL have one clock; reset is asynchronous and active-low: clk  in  1  rising-edge clock.
REQ-004 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have port imem_addr  out  32  byte address to instruction memory read port.
REQ-006 SHALL have port imem_data  in  32  little-endian instruction word returned combinationally for imem_addr.
REQ-007 SHALL have port redirect_valid  in  1  branch/jump redirect request.
REQ-008 SHALL have port redirect_pc  in  32  redirect target.
REQ-009 SHALL have port out_valid  out  1  instruction available to decode.
REQ-010 SHALL have port out_ready  in  1  decode accepts instruction.
REQ-011 SHALL have port out_instr  out  32  instruction at buffer head.
REQ-012 SHALL have port out_pc  out  32  PC of out_instr.
REQ-013 SHALL have port fetch_cnt  out  32  accepted-instruction count (present only per REQ-031).

Function
REQ-014 SHALL drive imem_addr from the PC register every cycle.
REQ-015 SHALL push {PC, imem_data} into the buffer and advance PC by 4 in any cycle where push is allowed and redirect_valid=0.
REQ-016 SHALL allow push when the buffer is not full, or when full and a pop occurs in the same cycle.
REQ-017 SHALL hold PC and not push when the buffer is full and no pop occurs.
REQ-018 SHALL pop the head on out_valid=1 and out_ready=1.
REQ-019 SHALL present a pushed instruction on out_* no earlier than the cycle after its fetch; latency from PC load to out_valid is exactly 1 cycle with out_ready=1.
REQ-020 SHALL assert out_valid iff the buffer is non-empty; when empty, out_instr=32'h0000_0013 (NOP) and out_pc=0.
REQ-021 SHALL keep out_instr/out_pc stable while out_valid=1 and out_ready=0.
REQ-022 SHALL on redirect_valid=1 flush all buffer entries, suppress push and pop that cycle, and load PC with {redirect_pc[31:2], 2'b00}.
REQ-023 SHALL give redirect priority over simultaneous push and pop; out_valid=0 in the cycle after a redirect.
REQ-024 SHALL wrap PC modulo 2^32 (32'hFFFF_FFFC + 4 = 32'h0000_0000).
REQ-025 SHALL preserve FIFO order; no entry is duplicated or dropped except by flush.

Reset
REQ-026 SHALL on rst_n=0 immediately set PC=RESET_PC, buffer empty, out_valid=0, out_instr=NOP, out_pc=0, fetch_cnt=0.
REQ-027 SHALL discard in-flight buffer contents on reset asserted mid-operation.
REQ-028 SHALL fetch from RESET_PC in the first clock after rst_n deasserts.

Configuration
REQ-029 SHALL gate the counter with macro ZEDERN_FETCH_CNT_EN.
REQ-030 SHALL, with ZEDERN_FETCH_CNT_EN defined, increment fetch_cnt by 1 per out handshake, wrapping at 2^32, not counting flushed entries.
REQ-031 SHALL, without ZEDERN_FETCH_CNT_EN, omit the fetch_cnt port and counter logic entirely.

Structure
REQ-032 SHALL take XLEN (32), INSTR_BYTES (4) and NOP_INSTR (32'h0000_0013) from shared package zedern_pkg.
REQ-033 SHALL implement the buffer as sub-module fetch_fifo (synchronous push/pop, flush, full/empty flags).

Verification
REQ-034 SHALL cover reset: RESET_PC=32'h100, release rst_n, out_ready=1 -> out_pc 0x100, 0x104, 0x108 on consecutive cycles, out_valid=1 from cycle 1.
REQ-035 SHALL cover backpressure: out_ready=0 for 5 cycles -> buffer fills at 2 entries, PC holds at start+8, out_pc stable; release -> no gap, no duplicate.
REQ-036 SHALL cover redirect: redirect_valid=1 with redirect_pc=32'h203 while buffer full and out_ready=1 -> next cycle out_valid=0, following cycle out_pc=0x200.
REQ-037 SHALL cover wrap: RESET_PC=32'hFFFF_FFF8 -> out_pc 0xFFFFFFF8, 0xFFFFFFFC, 0x0.
REQ-038 SHALL cover mid-run reset: assert rst_n=0 with 2 entries buffered -> out_valid=0 asynchronously, fetch_cnt=0.
REQ-039 SHALL cover counter (macro on): 10 handshakes plus one redirect flushing 2 entries -> fetch_cnt=10.
